// File: rtl/enq_pkt_desc_arb.sv
// Weighted round-robin scheduler draining NUM_SRC descriptor FIFOs into one downstream FIFO.
// Optional per-source issue counters and stat_sel/stat_cnt ports under `ENQ_PKT_DESC_ARB_STATS_EN.
module enq_pkt_desc_arb #(
  parameter int NUM_SRC   = 4,
  parameter int SRC_NBITS = 2,
  parameter int WT_NBITS  = 4,
  parameter int DESC_W    = 32
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic [NUM_SRC-1:0]                src_empty,
  input  logic [NUM_SRC-1:0][DESC_W-1:0]    src_desc,
  output logic [NUM_SRC-1:0]                src_rd,
  input  logic                              out_full,
  input  logic                              out_fullm1,
  output logic                              out_wr,
  output logic [DESC_W-1:0]                 out_desc,
  output logic [SRC_NBITS-1:0]              out_src,
  input  logic [NUM_SRC*WT_NBITS-1:0]       cfg_quota,
`ifdef ENQ_PKT_DESC_ARB_STATS_EN
  input  logic [SRC_NBITS-1:0]              stat_sel,
  output logic [31:0]                       stat_cnt,
`endif
  output logic                              arb_busy
);

  typedef enum logic {ST_IDLE = 1'b0, ST_BURST = 1'b1} state_e;

  state_e                state_q, state_d;
  logic [SRC_NBITS-1:0]  cur_src_q, cur_src_d, last_src_q, last_src_d;
  logic [WT_NBITS-1:0]   quota_q, quota_d, burst_cnt_q, burst_cnt_d;
  logic                  out_wr_q, out_wr_d;
  logic [DESC_W-1:0]     out_desc_q, out_desc_d;
  logic [SRC_NBITS-1:0]  out_src_q, out_src_d;

  logic [NUM_SRC-1:0]    elig_s;
  logic                  found_s, space_s, issue_s;
  logic [SRC_NBITS-1:0]  pick_s, idx_s;
  logic [SRC_NBITS:0]    sum_s;
  logic [WT_NBITS-1:0]   cnt_inc_s, cur_cfg_s;

  function automatic logic [WT_NBITS-1:0] quota_of(input logic [NUM_SRC*WT_NBITS-1:0] q, input int i);
    return q[i*WT_NBITS +: WT_NBITS];
  endfunction

  // Search from last_src+1 with wrap; walking downward lets the nearest eligible source win.
  always_comb begin
    elig_s  = '0;
    found_s = 1'b0;
    pick_s  = '0;
    sum_s   = '0;
    idx_s   = '0;
    for (int i = 0; i < NUM_SRC; i++) begin
      elig_s[i] = ~src_empty[i] & (quota_of(cfg_quota, i) != '0);
    end
    for (int k = NUM_SRC; k >= 1; k--) begin
      sum_s   = {1'b0, last_src_q} + (SRC_NBITS+1)'(k);
      sum_s   = (sum_s >= (SRC_NBITS+1)'(NUM_SRC)) ? sum_s - (SRC_NBITS+1)'(NUM_SRC) : sum_s;
      idx_s   = sum_s[SRC_NBITS-1:0];
      pick_s  = elig_s[idx_s] ? idx_s : pick_s;
      found_s = found_s | elig_s[idx_s];
    end
  end

  // Grant/burst sequencing; the in-flight registered write counts against downstream space.
  always_comb begin
    state_d     = state_q;
    cur_src_d   = cur_src_q;
    last_src_d  = last_src_q;
    quota_d     = quota_q;
    burst_cnt_d = burst_cnt_q;
    out_wr_d    = 1'b0;
    out_desc_d  = out_desc_q;
    out_src_d   = out_src_q;
    src_rd      = '0;
    issue_s     = 1'b0;
    space_s     = ~out_full & ~(out_fullm1 & out_wr_q);
    cnt_inc_s   = burst_cnt_q + WT_NBITS'(1);
    cur_cfg_s   = quota_of(cfg_quota, int'(cur_src_q));
    case (state_q)
      ST_IDLE: begin
        if (found_s) begin
          cur_src_d   = pick_s;
          quota_d     = quota_of(cfg_quota, int'(pick_s));
          burst_cnt_d = '0;
          state_d     = ST_BURST;
        end else begin
          state_d     = ST_IDLE;
        end
      end
      ST_BURST: begin
        issue_s = ~rst & ~src_empty[cur_src_q] & space_s & (burst_cnt_q < quota_q);
        if (issue_s) begin
          src_rd[cur_src_q] = 1'b1;
          out_wr_d          = 1'b1;
          out_desc_d        = src_desc[cur_src_q];
          out_src_d         = cur_src_q;
          burst_cnt_d       = cnt_inc_s;
        end else begin
          burst_cnt_d       = burst_cnt_q;
        end
        // A quota dropped to zero ends the burst now; other quota edits wait for the next grant.
        if (src_empty[cur_src_q] || (issue_s && (cnt_inc_s == quota_q)) || (cur_cfg_s == '0)) begin
          last_src_d = cur_src_q;
          state_d    = ST_IDLE;
        end else begin
          state_d    = ST_BURST;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State and registered downstream write port.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cur_src_q   <= '0;
      last_src_q  <= SRC_NBITS'(NUM_SRC-1);
      quota_q     <= '0;
      burst_cnt_q <= '0;
      out_wr_q    <= 1'b0;
      out_desc_q  <= '0;
      out_src_q   <= '0;
    end else begin
      state_q     <= state_d;
      cur_src_q   <= cur_src_d;
      last_src_q  <= last_src_d;
      quota_q     <= quota_d;
      burst_cnt_q <= burst_cnt_d;
      out_wr_q    <= out_wr_d;
      out_desc_q  <= out_desc_d;
      out_src_q   <= out_src_d;
    end
  end

  assign out_wr   = out_wr_q;
  assign out_desc = out_desc_q;
  assign out_src  = out_src_q;
  assign arb_busy = (state_q == ST_BURST);

`ifdef ENQ_PKT_DESC_ARB_STATS_EN
  logic [31:0] stat_q [NUM_SRC];
  logic [31:0] stat_d [NUM_SRC];
  logic [31:0] stat_cnt_q, stat_cnt_d;

  // Saturating per-source issue counters and registered readback mux.
  always_comb begin
    for (int i = 0; i < NUM_SRC; i++) begin
      stat_d[i] = (issue_s && (cur_src_q == SRC_NBITS'(i)) && (stat_q[i] != 32'hFFFF_FFFF)) ?
                  stat_q[i] + 32'd1 : stat_q[i];
    end
    stat_cnt_d = (int'(stat_sel) < NUM_SRC) ? stat_q[stat_sel] : 32'd0;
  end

  // Counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_SRC; i++) begin
        stat_q[i] <= 32'd0;
      end
      stat_cnt_q <= 32'd0;
    end else begin
      stat_q     <= stat_d;
      stat_cnt_q <= stat_cnt_d;
    end
  end

  assign stat_cnt = stat_cnt_q;
`endif

endmodule

// File: tb/tb_enq_pkt_desc_arb.sv
// Directed bench for enq_pkt_desc_arb: bench-owned source/downstream FIFOs plus a
// transaction-level weighted round-robin model of the expected output stream.
module tb_enq_pkt_desc_arb;
  localparam int NS = 4;
  localparam int SB = 2;
  localparam int WB = 4;
  localparam int DW = 32;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [NS-1:0]         src_empty;
  logic [NS-1:0][DW-1:0] src_desc;
  logic [NS-1:0]         src_rd;
  logic                  out_full, out_fullm1, out_wr;
  logic [DW-1:0]         out_desc;
  logic [SB-1:0]         out_src;
  logic [NS*WB-1:0]      cfg_quota;
  logic                  arb_busy;
`ifdef ENQ_PKT_DESC_ARB_STATS_EN
  logic [SB-1:0]         stat_sel;
  logic [31:0]           stat_cnt;
  logic [SB-1:0]         stat_sel_v;
`endif

  always #5 clk = ~clk;

  enq_pkt_desc_arb #(.NUM_SRC(NS), .SRC_NBITS(SB), .WT_NBITS(WB), .DESC_W(DW)) dut (
    .clk(clk), .rst(rst), .src_empty(src_empty), .src_desc(src_desc), .src_rd(src_rd),
    .out_full(out_full), .out_fullm1(out_fullm1), .out_wr(out_wr), .out_desc(out_desc),
    .out_src(out_src), .cfg_quota(cfg_quota),
`ifdef ENQ_PKT_DESC_ARB_STATS_EN
    .stat_sel(stat_sel), .stat_cnt(stat_cnt),
`endif
    .arb_busy(arb_busy));

  logic [DW-1:0] src_q [NS][$];
  logic [DW-1:0] exp_desc [$];
  logic [SB-1:0] exp_src [$];
  logic [SB-1:0] hist [$];
  int            pop_cyc [$];
  int            pops [NS];
  int            n_tests, n_fail, cyc, nwr, occ, depth, full_after, trk_src;
  bit            rst_v, force_full, drain_en, wr_pend;
  logic [NS*WB-1:0] quota_v;
  logic [NS-1:0] rd_prev;

  task automatic chk(input bit ok, input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [DW-1:0] mk(input int s, input int n);
    return 32'hA500_0000 | (DW'(s) << 16) | DW'(n);
  endfunction

  // Expected stream: repeatedly grant the next source after the last one that has data and a
  // nonzero quota; it sends min(quota, remaining) descriptors.
  function automatic void build_exp();
    int ptr [NS];
    int last, sel, cnt, q, idx;
    bit found;
    for (int i = 0; i < NS; i++) ptr[i] = 0;
    last = NS - 1;
    exp_desc.delete();
    exp_src.delete();
    for (int g = 0; g < 1000; g++) begin
      found = 1'b0;
      sel = 0;
      for (int k = 1; k <= NS; k++) begin
        idx = (last + k) % NS;
        if (!found && ptr[idx] < src_q[idx].size() && quota_v[idx*WB +: WB] != 4'd0) begin
          found = 1'b1;
          sel = idx;
        end
      end
      if (!found) break;
      q = int'(quota_v[sel*WB +: WB]);
      cnt = 0;
      while (cnt < q && ptr[sel] < src_q[sel].size()) begin
        exp_desc.push_back(src_q[sel][ptr[sel]]);
        exp_src.push_back(SB'(sel));
        ptr[sel]++;
        cnt++;
      end
      last = sel;
    end
  endfunction

  // One clock: apply pops, check outputs against the model, drive inputs, check src_rd.
  task automatic step();
    logic [DW-1:0] ed;
    logic [SB-1:0] es;
    @(negedge clk);
    cyc++;
    for (int i = 0; i < NS; i++) begin
      if (rd_prev[i]) begin
        chk(src_q[i].size() > 0, "pop_nonempty", 64'(src_q[i].size()), 64'd1);
        if (src_q[i].size() > 0) void'(src_q[i].pop_front());
        pops[i]++;
        if (i == trk_src) pop_cyc.push_back(cyc);
      end
    end
    if (wr_pend) occ++;
    chk(occ <= depth, "no_overflow", 64'(occ), 64'(depth));
    if (drain_en && occ > 0) occ--;
    if (rst) begin
      chk(out_wr == 1'b0 && arb_busy == 1'b0 && out_src == '0 && out_desc == '0, "reset_outputs",
          {out_wr, arb_busy, out_src, out_desc}, 64'd0);
    end else if (out_wr) begin
      nwr++;
      hist.push_back(out_src);
      chk(out_full == 1'b0, "wr_after_full", 64'(out_full), 64'd0);
      if (exp_desc.size() == 0) begin
        chk(1'b0, "extra_write", 64'(out_desc), 64'd0);
      end else begin
        ed = exp_desc.pop_front();
        es = exp_src.pop_front();
        chk(out_src == es, "out_src", 64'(out_src), 64'(es));
        chk(out_desc == ed, "out_desc", 64'(out_desc), 64'(ed));
      end
    end
    wr_pend = out_wr;
    if (full_after > 0 && nwr >= full_after) force_full = 1'b1;
    rst        = rst_v;
    cfg_quota  = quota_v;
    out_full   = (occ >= depth) || force_full;
    out_fullm1 = (occ == depth - 1);
    for (int i = 0; i < NS; i++) begin
      src_empty[i] = (src_q[i].size() == 0);
      src_desc[i]  = (src_q[i].size() > 0) ? src_q[i][0] : '0;
    end
`ifdef ENQ_PKT_DESC_ARB_STATS_EN
    stat_sel = stat_sel_v;
`endif
    #1;
    rd_prev = src_rd;
    chk($countones(src_rd) <= 1 && (src_rd & src_empty) == '0 && !(rst && src_rd != '0),
        "src_rd_legal", 64'(src_rd), 64'(~src_empty));
  endtask

  task automatic reset_dut();
    rst_v = 1'b1;
    step();
    step();
    for (int i = 0; i < NS; i++) begin
      src_q[i].delete();
      pops[i] = 0;
    end
    exp_desc.delete();
    exp_src.delete();
    occ = 0; wr_pend = 1'b0; force_full = 1'b0; full_after = 0; drain_en = 1'b1; depth = 16;
    quota_v = '0;
    step();
  endtask

  task automatic load(input int s, input int n, input int q);
    for (int k = 0; k < n; k++) src_q[s].push_back(mk(s, k));
    quota_v[s*WB +: WB] = WB'(q);
  endtask

  task automatic start_test();
    build_exp();
    hist.delete();
    pop_cyc.delete();
    nwr = 0;
    for (int i = 0; i < NS; i++) pops[i] = 0;
    rst_v = 1'b0;
  endtask

  task automatic finish_test(input int max_cyc);
    for (int c = 0; c < max_cyc && exp_desc.size() > 0; c++) step();
    chk(exp_desc.size() == 0, "drain_complete", 64'(exp_desc.size()), 64'd0);
    repeat (6) step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [SB-1:0] ord [10];
    int p0, p1;
    ord = '{2'd0, 2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd3, 2'd3, 2'd3, 2'd3};
    rst = 1'b1; src_empty = '1; src_desc = '0; out_full = 1'b0; out_fullm1 = 1'b0; cfg_quota = '0;
    n_tests = 0; n_fail = 0; cyc = 0; nwr = 0; occ = 0; depth = 16; full_after = 0; trk_src = 1;
    rst_v = 1'b1; force_full = 1'b0; drain_en = 1'b1; wr_pend = 1'b0; quota_v = '0; rd_prev = '0;
    for (int i = 0; i < NS; i++) pops[i] = 0;
`ifdef ENQ_PKT_DESC_ARB_STATS_EN
    stat_sel_v = '0;
    stat_sel = '0;
`endif

    // Reset held with every source non-empty: nothing may be popped or written.
    for (int i = 0; i < NS; i++) load(i, 2, 4);
    repeat (3) step();
    for (int i = 0; i < NS; i++) chk(src_q[i].size() == 2, "reset_no_pop", 64'(src_q[i].size()), 64'd2);
    reset_dut();

    // Single source, 5 descriptors, quota 4: four back-to-back pops, one idle, one pop.
    load(1, 5, 4);
    start_test();
    finish_test(60);
    chk(pop_cyc.size() == 5, "single_pop_count", 64'(pop_cyc.size()), 64'd5);
    if (pop_cyc.size() == 5) begin
      chk(pop_cyc[1] - pop_cyc[0] == 1, "b2b_gap1", 64'(pop_cyc[1] - pop_cyc[0]), 64'd1);
      chk(pop_cyc[2] - pop_cyc[1] == 1, "b2b_gap2", 64'(pop_cyc[2] - pop_cyc[1]), 64'd1);
      chk(pop_cyc[3] - pop_cyc[2] == 1, "b2b_gap3", 64'(pop_cyc[3] - pop_cyc[2]), 64'd1);
      chk(pop_cyc[4] - pop_cyc[3] == 2, "turnaround_gap", 64'(pop_cyc[4] - pop_cyc[3]), 64'd2);
    end
    reset_dut();

    // Four sources, quotas 1,2,3,4: fixed grant pattern.
    for (int i = 0; i < NS; i++) load(i, 8, i + 1);
    start_test();
    finish_test(300);
    chk(hist.size() == 32, "wrr_total", 64'(hist.size()), 64'd32);
    for (int k = 0; k < 10; k++) begin
      if (k < hist.size()) chk(hist[k] == ord[k], "grant_order", 64'(hist[k]), 64'(ord[k]));
    end
    reset_dut();

    // Downstream depth 4, no draining: exactly four writes, then resume.
    depth = 4; drain_en = 1'b0;
    load(0, 8, 8);
    start_test();
    repeat (15) step();
    chk(nwr == 4, "stall_at_depth", 64'(nwr), 64'd4);
    chk(occ == 4, "depth_occupancy", 64'(occ), 64'd4);
    drain_en = 1'b1;
    finish_test(100);
    reset_dut();

    // out_full forced after three writes: no fourth write until it drops.
    full_after = 3;
    load(3, 6, 6);
    start_test();
    for (int c = 0; c < 30 && nwr < 3; c++) step();
    repeat (8) step();
    chk(nwr == 3, "hold_while_full", 64'(nwr), 64'd3);
    full_after = 0; force_full = 1'b0;
    finish_test(60);
    reset_dut();

    // Quota 0 source is never popped.
    load(2, 8, 0);
    load(1, 3, 2);
    start_test();
    finish_test(60);
    chk(src_q[2].size() == 8, "quota0_never_popped", 64'(src_q[2].size()), 64'd8);
    chk(nwr == 3, "quota0_other_src", 64'(nwr), 64'd3);
    reset_dut();

    // Quota forced to 0 mid-burst: burst ends next cycle and no further pops.
    load(2, 8, 4);
    start_test();
    for (int c = 0; c < 20 && pops[2] < 1; c++) step();
    p0 = pops[2];
    quota_v[2*WB +: WB] = 4'd0;
    step();
    step();
    chk(arb_busy == 1'b0, "quota0_exit", 64'(arb_busy), 64'd0);
    p1 = pops[2];
    chk(p1 - p0 <= 2, "quota0_exit_pops", 64'(p1 - p0), 64'd2);
    repeat (6) step();
    chk(pops[2] == p1, "quota0_no_more_pops", 64'(pops[2]), 64'(p1));
    reset_dut();

    // Reset mid-burst: pops stop and outputs return to reset values.
    load(0, 8, 8);
    start_test();
    for (int c = 0; c < 20 && pops[0] < 2; c++) step();
    rst_v = 1'b1;
    step();
    p0 = pops[0];
    repeat (3) step();
    chk(pops[0] == p0, "no_pop_in_reset", 64'(pops[0]), 64'(p0));
    reset_dut();

`ifdef ENQ_PKT_DESC_ARB_STATS_EN
    // 100 descriptors from source 3; counters read back one cycle after selection.
    load(3, 100, 15);
    start_test();
    finish_test(300);
    stat_sel_v = 2'd3;
    step();
    step();
    chk(stat_cnt == 32'd100, "stat_src3", 64'(stat_cnt), 64'd100);
    for (int s = 0; s < 3; s++) begin
      stat_sel_v = SB'(s);
      step();
      step();
      chk(stat_cnt == 32'd0, "stat_other", 64'(stat_cnt), 64'd0);
    end
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
